// File: rtl/isqrt_iter_pkg.sv
// Shared types and widths for the iterative radix-4 integer square root.
package isqrt_iter_pkg;

    localparam int OPERAND_W   = 32;
    localparam int ROOT_W      = 16;
    localparam int REM_W       = 18;
    localparam int ITER_COUNT  = 16;
    localparam int CNT_W       = 4;

    // Controller states: waiting, iterating, presenting the result for one cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } isqrt_state_t;

endpackage

// File: rtl/isqrt_iter_fsm_if.sv
// Request/result bundle between an initiator and the square-root unit.
interface isqrt_iter_fsm_if;
    import isqrt_iter_pkg::*;

    logic                 x_vld;
    logic [OPERAND_W-1:0] x;
    logic                 y_vld;
    logic [ROOT_W-1:0]    y;
    logic                 busy;

    modport master (
        output x_vld,
        output x,
        input  y_vld,
        input  y,
        input  busy
    );

    modport slave (
        input  x_vld,
        input  x,
        output y_vld,
        output y,
        output busy
    );

endinterface

// File: rtl/isqrt_iter_step.sv
// One radix-4 digit of the restoring square root: brings in two radicand bits
// and decides the next root bit with a single trial subtraction.
module isqrt_iter_step
    import isqrt_iter_pkg::*;
(
    input  logic [REM_W-1:0]  rem_i,
    input  logic [ROOT_W-1:0] root_i,
    input  logic [1:0]        bits_i,
    output logic [REM_W-1:0]  rem_o,
    output logic [ROOT_W-1:0] root_o
);

    logic [REM_W-1:0] remShifted;
    logic [REM_W-1:0] trial;
    logic             fits;

    // The remainder stays below 2^16 before the last shift, so the 18-bit
    // shifted remainder and the trial value never lose significant bits.
    always_comb begin
        remShifted = {rem_i[REM_W-3:0], bits_i};
        trial      = {root_i, 2'b01};
        fits       = (remShifted >= trial);
        rem_o      = remShifted;
        root_o     = {root_i[ROOT_W-2:0], 1'b0};
        if (fits) begin
            rem_o  = remShifted - trial;
            root_o = {root_i[ROOT_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Iterative 32-bit integer square root: sixteen radix-4 steps per request,
// fixed latency, one-cycle result strobe and a held result register.
module isqrt_iter_fsm
    import isqrt_iter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    isqrt_iter_fsm_if.slave   bus
);

    isqrt_state_t         state_q;
    logic [OPERAND_W-1:0] x_q;
    logic [REM_W-1:0]     rem_q;
    logic [ROOT_W-1:0]    root_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ROOT_W-1:0]    y_q;
    logic                 y_vld_q;
    logic                 busy_q;

    logic [REM_W-1:0]     rem_d;
    logic [ROOT_W-1:0]    root_d;

    isqrt_iter_step u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (x_q[OPERAND_W-1:OPERAND_W-2]),
        .rem_o  (rem_d),
        .root_o (root_d)
    );

    // Controller: accepts in IDLE or DONE, iterates in CALC (consuming the
    // radicand MSB-first by shifting it left), and registers busy/y_vld/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    y_vld_q <= 1'b0;
                    if (bus.x_vld) begin
                        x_q     <= bus.x;
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= CNT_W'(ITER_COUNT - 1);
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    x_q    <= {x_q[OPERAND_W-3:0], 2'b00};
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    if (cnt_q == '0) begin
                        y_q     <= root_d;
                        y_vld_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    y_vld_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.y     = y_q;
    assign bus.y_vld = y_vld_q;
    assign bus.busy  = busy_q;

endmodule
